// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: framing states, default geometry and channel slicing.
// Used by both ends of the link so slot placement in the parallel word stays consistent.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } tdm_state_e;

    localparam int TDM_WIDTH = 8;
    localparam int TDM_NCH   = 4;

    // LSB position of channel slot in the packed parallel word (slot k at [k*width +: width]).
    function automatic int unsigned ch_lo(input int unsigned slot, input int unsigned width);
        return slot * width;
    endfunction

endpackage

// File: rtl/tdm_deserializer_if.sv
// Serial-in / parallel-out bundle of the TDM receiver; master is the line side, slave the deserializer.
// No backpressure: the line side paces the link with bit_en only.
interface tdm_deserializer_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int NCH   = TDM_NCH
);
    logic                   bit_en;
    logic                   sync;
    logic                   sdata;
    logic [NCH*WIDTH-1:0]   ch_data;
    logic                   frame_valid;
    logic                   frame_err;
    logic                   locked;

    modport master (
        output bit_en, sync, sdata,
        input  ch_data, frame_valid, frame_err, locked
    );

    modport slave (
        input  bit_en, sync, sdata,
        output ch_data, frame_valid, frame_err, locked
    );
endinterface

// File: rtl/tdm_bit_shifter.sv
// MSB-first word shifter with bit counter; word/word_done are combinational on the sampled bit.
// No backpressure: shifts whenever shift_en is high; restart makes the sampled bit bit 0 of a new word.
module tdm_bit_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             restart,
    input  logic             sdata,
    output logic [WIDTH-1:0] word,
    output logic             word_start,
    output logic             word_done
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (shift_en) begin
            shreg_d = {shreg_q[WIDTH-2:0], sdata};
            if (restart) begin
                bit_cnt_d = CW'(1);
            end else if (bit_cnt_q == CW'(WIDTH - 1)) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign word       = {shreg_q[WIDTH-2:0], sdata};
    assign word_start = (bit_cnt_q == '0);
    assign word_done  = shift_en && !restart && (bit_cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/tdm_deserializer.sv
// Recovers NCH channel words from a sync-framed bit-serial TDM stream; frame_valid/ch_data one clk after the last bit.
// No backpressure: every bit_en bit is consumed; errors pulse frame_err and never touch ch_data.
module tdm_deserializer
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int NCH   = TDM_NCH
) (
    input  logic               clk,
    input  logic               rst,
    tdm_deserializer_if.slave  bus
);
    localparam int SW = $clog2(NCH);
    localparam int FW = NCH * WIDTH;

    tdm_state_e    state_q, state_d;
    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [FW-1:0] buf_q, buf_d;
    logic [FW-1:0] ch_data_q, ch_data_d;
    logic          frame_valid_q, frame_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          locked_q, locked_d;

    logic             shift_en;
    logic             restart;
    logic [WIDTH-1:0] word;
    logic             word_start;
    logic             word_done;
    logic             frame_start;

    tdm_bit_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (shift_en),
        .restart    (restart),
        .sdata      (bus.sdata),
        .word       (word),
        .word_start (word_start),
        .word_done  (word_done)
    );

    assign frame_start = word_start && (slot_cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        slot_cnt_d    = slot_cnt_q;
        buf_d         = buf_q;
        ch_data_d     = ch_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        locked_d      = locked_q;
        shift_en      = 1'b0;
        restart       = 1'b0;
        if (bus.bit_en) begin
            case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        shift_en   = 1'b1;
                        restart    = 1'b1;
                        slot_cnt_d = '0;
                        state_d    = RECV;
                    end
                end
                RECV: begin
                    if (frame_start) begin
                        if (bus.sync) begin
                            shift_en = 1'b1;
                            restart  = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            locked_d    = 1'b0;
                            state_d     = HUNT;
                        end
                    end else if (bus.sync) begin
                        // Sync mid-frame: drop the partial frame and realign on this bit.
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        shift_en    = 1'b1;
                        restart     = 1'b1;
                        slot_cnt_d  = '0;
                    end else begin
                        shift_en = 1'b1;
                        if (word_done) begin
                            buf_d[ch_lo(32'(slot_cnt_q), WIDTH) +: WIDTH] = word;
                            if (slot_cnt_q == SW'(NCH - 1)) begin
                                slot_cnt_d    = '0;
                                ch_data_d     = buf_d;
                                frame_valid_d = 1'b1;
                                locked_d      = 1'b1;
                            end else begin
                                slot_cnt_d = slot_cnt_q + SW'(1);
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_cnt_q    <= '0;
            buf_q         <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            buf_q         <= buf_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.ch_data     = ch_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.locked      = locked_q;

endmodule

// File: tb/tb_tdm_deserializer.sv
// Scoreboard bench for tdm_deserializer: expected output events queued as bits are driven, popped on DUT pulses.
// Each event carries the clock edge it must appear on, so latency and spacing are checked too.
module tb_tdm_deserializer;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int FB = W * N;

    localparam int EV_NONE  = 0;
    localparam int EV_VALID = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int            kind;
        int            stamp;
        logic [FB-1:0] data;
        logic          lk;
    } ev_t;

    logic clk;
    logic rst;
    int   edges;
    int   checks;
    int   errors;
    int   gap;
    logic [FB-1:0] last_good;
    ev_t  exp_q[$];

    tdm_deserializer_if #(.WIDTH(W), .NCH(N)) bus ();

    tdm_deserializer #(.WIDTH(W), .NCH(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edges = 0;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, act, exp, edges);
        end
    endtask

    // Drive one bit (after gap idle cycles with noise on sync/sdata); optionally expect an output event.
    task automatic send_bit(input logic s, input logic d, input int ev);
        ev_t e;
        repeat (gap) begin
            bus.bit_en = 1'b0;
            bus.sync   = 1'($urandom);
            bus.sdata  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.bit_en = 1'b1;
        bus.sync   = s;
        bus.sdata  = d;
        if (ev != EV_NONE) begin
            e.kind  = ev;
            e.stamp = edges + 1;
            if (ev == EV_VALID) begin
                e.data    = last_good;
                e.lk      = 1'b1;
            end else begin
                e.data    = last_good;
                e.lk      = 1'b0;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.bit_en = 1'b0;
        bus.sync   = 1'($urandom);
        bus.sdata  = 1'($urandom);
    endtask

    // Send the first nbits of a frame, sync on bit 0; a full frame expects frame_valid on its last bit.
    task automatic send_frame(input logic [FB-1:0] data, input int nbits, input bit err_first);
        int idx;
        int ev;
        logic [FB-1:0] prev;
        idx  = 0;
        prev = last_good;
        for (int k = 0; k < N; k++) begin
            for (int b = W - 1; b >= 0; b--) begin
                if (idx < nbits) begin
                    ev = EV_NONE;
                    if (idx == 0 && err_first) ev = EV_ERR;
                    if (idx == FB - 1) begin
                        ev        = EV_VALID;
                        last_good = data;
                    end
                    send_bit(idx == 0, data[k*W + b], ev);
                    last_good = (ev == EV_VALID) ? data : prev;
                    if (ev == EV_VALID) prev = data;
                end
                idx++;
            end
        end
    endtask

    task automatic send_nosync(input int nbits, input bit err_first);
        for (int i = 0; i < nbits; i++) begin
            send_bit(1'b0, 1'($urandom), (i == 0 && err_first) ? EV_ERR : EV_NONE);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_valid && bus.frame_err) check("valid_err_both", 2'b11, 2'b00);
            if (bus.frame_valid || bus.frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {bus.frame_valid, bus.frame_err}, 2'b00);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_kind", {bus.frame_valid, bus.frame_err},
                          (e.kind == EV_VALID) ? 2'b10 : 2'b01);
                    check("event_edge", 64'(edges), 64'(e.stamp));
                    check("event_ch_data", 64'(bus.ch_data), 64'(e.data));
                    check("event_locked", 64'(bus.locked), 64'(e.lk));
                end
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        gap        = 0;
        last_good  = '0;
        rst        = 1'b1;
        bus.bit_en = 1'b0;
        bus.sync   = 1'b0;
        bus.sdata  = 1'b0;
        #1;
        check("rst_ch_data", 64'(bus.ch_data), 64'h0);
        check("rst_valid", 64'(bus.frame_valid), 64'h0);
        check("rst_err", 64'(bus.frame_err), 64'h0);
        check("rst_locked", 64'(bus.locked), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("idle_locked", 64'(bus.locked), 64'h0);

        // Continuous bit_en, then sparse bit_en with noise in between.
        send_frame(32'hF00F3CA5, FB, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("locked_after_frame", 64'(bus.locked), 64'h1);
        check("ch_data_held", 64'(bus.ch_data), 64'hF00F3CA5);
        gap = 2;
        send_frame(32'hF00F3CA5, FB, 1'b0);
        gap = 0;

        // Back-to-back frames: stamps force exactly 32 bit_en apart.
        send_frame(32'h01020304, FB, 1'b0);
        send_frame(32'hDEADBEEF, FB, 1'b0);
        #1;
        check("b2b_locked", 64'(bus.locked), 64'h1);

        // Misaligned sync at bit 10 of the next frame, then a full frame from that sync bit.
        send_frame(32'h55AA55AA, 10, 1'b0);
        send_frame(32'h13579BDF, FB, 1'b1);

        // Missing sync at frame start -> HUNT; 40 sync-less bits produce nothing.
        send_nosync(40, 1'b1);
        check("hunt_locked", 64'(bus.locked), 64'h0);
        check("hunt_ch_data", 64'(bus.ch_data), 64'h13579BDF);
        send_frame(32'h0BADF00D, FB, 1'b0);

        // Asynchronous reset mid-frame, checked without a clock edge.
        send_frame(32'h12345678, 20, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_ch_data", 64'(bus.ch_data), 64'h0);
        check("arst_locked", 64'(bus.locked), 64'h0);
        check("arst_flags", {bus.frame_valid, bus.frame_err}, 2'b00);
        last_good = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(32'hCAFEBABE, FB, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("final_ch_data", 64'(bus.ch_data), 64'hCAFEBABE);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
